// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_control
// Description : Main control FSM for a multicycle MIPS-style datapath
//               (lw, sw, R-type, beq, j, addi) with a memory ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       PCEn,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       RegDst,
    output logic [1:0] ALUOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = S_FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        ALUSrcA     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        ALUOp       = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;

        case (r_state)
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                // IR and PC only load in the cycle the instruction word arrives
                IRWrite = MemReady;
                PCWrite = MemReady;
                w_next  = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (Op)
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_RTYPE:       w_next = S_EXEC;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_J:           w_next = S_JUMP;
                    c_OP_ADDI:        w_next = S_ADDIEX;
                    default:          w_next = S_FETCH;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (r_state == S_ADDIEX) begin
                    w_next = S_ADDIWB;
                end else begin
                    w_next = (Op == c_OP_LW) ? S_MEMRD : S_MEMWR;
                end
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                w_next  = MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                w_next   = MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
                w_next  = S_ALUWB;
            end
            S_ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            default: begin
                w_next = S_FETCH;
            end
        endcase
    end

    assign PCEn  = PCWrite | (PCWriteCond & Zero);
    assign State = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_control
// Description : Directed, table-driven self-checking bench for multicycle_control.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] Op;
    logic       Zero;
    logic       MemReady;
    logic       PCWrite, PCWriteCond, PCEn, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0] ALUOp, ALUSrcB, PCSource;
    logic [3:0] State;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Zero       (Zero),
        .MemReady   (MemReady),
        .PCWrite    (PCWrite),
        .PCWriteCond(PCWriteCond),
        .PCEn       (PCEn),
        .IorD       (IorD),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .IRWrite    (IRWrite),
        .ALUSrcA    (ALUSrcA),
        .RegWrite   (RegWrite),
        .RegDst     (RegDst),
        .ALUOp      (ALUOp),
        .ALUSrcB    (ALUSrcB),
        .PCSource   (PCSource),
        .State      (State)
    );

    typedef struct packed {
        logic       pcw, pcwc, iord, mrd, mwr, m2r, irw, srca, regw, rdst, pcen;
        logic [1:0] aluop, srcb, pcsrc;
    } outs_t;

    typedef struct {
        logic       rst;
        logic [5:0] op;
        logic       zero;
        logic       mr;
        logic [3:0] st;
        outs_t      o;
    } vec_t;

    // Hand-derived expected output sets per state (and handshake/flag condition)
    localparam outs_t O_FETCH_RDY = '{pcw:1'b1, pcwc:1'b0, iord:1'b0, mrd:1'b1, mwr:1'b0, m2r:1'b0, irw:1'b1, srca:1'b0, regw:1'b0, rdst:1'b0, pcen:1'b1, aluop:2'b00, srcb:2'b01, pcsrc:2'b00};
    localparam outs_t O_FETCH_STL = '{pcw:1'b0, pcwc:1'b0, iord:1'b0, mrd:1'b1, mwr:1'b0, m2r:1'b0, irw:1'b0, srca:1'b0, regw:1'b0, rdst:1'b0, pcen:1'b0, aluop:2'b00, srcb:2'b01, pcsrc:2'b00};
    localparam outs_t O_DECODE    = '{pcw:1'b0, pcwc:1'b0, iord:1'b0, mrd:1'b0, mwr:1'b0, m2r:1'b0, irw:1'b0, srca:1'b0, regw:1'b0, rdst:1'b0, pcen:1'b0, aluop:2'b00, srcb:2'b11, pcsrc:2'b00};
    localparam outs_t O_MEMADR    = '{pcw:1'b0, pcwc:1'b0, iord:1'b0, mrd:1'b0, mwr:1'b0, m2r:1'b0, irw:1'b0, srca:1'b1, regw:1'b0, rdst:1'b0, pcen:1'b0, aluop:2'b00, srcb:2'b10, pcsrc:2'b00};
    localparam outs_t O_MEMRD     = '{pcw:1'b0, pcwc:1'b0, iord:1'b1, mrd:1'b1, mwr:1'b0, m2r:1'b0, irw:1'b0, srca:1'b0, regw:1'b0, rdst:1'b0, pcen:1'b0, aluop:2'b00, srcb:2'b00, pcsrc:2'b00};
    localparam outs_t O_MEMWB     = '{pcw:1'b0, pcwc:1'b0, iord:1'b0, mrd:1'b0, mwr:1'b0, m2r:1'b1, irw:1'b0, srca:1'b0, regw:1'b1, rdst:1'b0, pcen:1'b0, aluop:2'b00, srcb:2'b00, pcsrc:2'b00};
    localparam outs_t O_MEMWR     = '{pcw:1'b0, pcwc:1'b0, iord:1'b1, mrd:1'b0, mwr:1'b1, m2r:1'b0, irw:1'b0, srca:1'b0, regw:1'b0, rdst:1'b0, pcen:1'b0, aluop:2'b00, srcb:2'b00, pcsrc:2'b00};
    localparam outs_t O_EXEC      = '{pcw:1'b0, pcwc:1'b0, iord:1'b0, mrd:1'b0, mwr:1'b0, m2r:1'b0, irw:1'b0, srca:1'b1, regw:1'b0, rdst:1'b0, pcen:1'b0, aluop:2'b10, srcb:2'b00, pcsrc:2'b00};
    localparam outs_t O_ALUWB     = '{pcw:1'b0, pcwc:1'b0, iord:1'b0, mrd:1'b0, mwr:1'b0, m2r:1'b0, irw:1'b0, srca:1'b0, regw:1'b1, rdst:1'b1, pcen:1'b0, aluop:2'b00, srcb:2'b00, pcsrc:2'b00};
    localparam outs_t O_BR_TAKEN  = '{pcw:1'b0, pcwc:1'b1, iord:1'b0, mrd:1'b0, mwr:1'b0, m2r:1'b0, irw:1'b0, srca:1'b1, regw:1'b0, rdst:1'b0, pcen:1'b1, aluop:2'b01, srcb:2'b00, pcsrc:2'b01};
    localparam outs_t O_BR_NOT    = '{pcw:1'b0, pcwc:1'b1, iord:1'b0, mrd:1'b0, mwr:1'b0, m2r:1'b0, irw:1'b0, srca:1'b1, regw:1'b0, rdst:1'b0, pcen:1'b0, aluop:2'b01, srcb:2'b00, pcsrc:2'b01};
    localparam outs_t O_JUMP      = '{pcw:1'b1, pcwc:1'b0, iord:1'b0, mrd:1'b0, mwr:1'b0, m2r:1'b0, irw:1'b0, srca:1'b0, regw:1'b0, rdst:1'b0, pcen:1'b1, aluop:2'b00, srcb:2'b00, pcsrc:2'b10};
    localparam outs_t O_ADDIWB    = '{pcw:1'b0, pcwc:1'b0, iord:1'b0, mrd:1'b0, mwr:1'b0, m2r:1'b0, irw:1'b0, srca:1'b0, regw:1'b1, rdst:1'b0, pcen:1'b0, aluop:2'b00, srcb:2'b00, pcsrc:2'b00};

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
    localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, ADDI = 6'b001000, BAD = 6'b111111;

    outs_t act;
    assign act = '{pcw:PCWrite, pcwc:PCWriteCond, iord:IorD, mrd:MemRead, mwr:MemWrite,
                   m2r:MemtoReg, irw:IRWrite, srca:ALUSrcA, regw:RegWrite, rdst:RegDst,
                   pcen:PCEn, aluop:ALUOp, srcb:ALUSrcB, pcsrc:PCSource};

    vec_t vq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic r, input logic [5:0] op, input logic z, input logic mr,
                       input logic [3:0] st, input outs_t o);
        vec_t v;
        v.rst = r; v.op = op; v.zero = z; v.mr = mr; v.st = st; v.o = o;
        vq.push_back(v);
    endtask

    task automatic run_latency(input logic [5:0] op, input int exp_cycles);
        int n;
        n = 0;
        reset = 1'b0; Op = op; Zero = 1'b0; MemReady = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (State != 4'd0 && n < 20);
        total++;
        if (n != exp_cycles) begin
            bad++;
            $display("FAIL latency op=%b: got %0d cycles, want %0d", op, n, exp_cycles);
        end
    endtask

    initial begin
        // lw straight through, reset row first (reset outputs = FETCH decode)
        add(1, RT,  0, 1, 4'd0,  O_FETCH_RDY);
        add(0, LW,  0, 1, 4'd0,  O_FETCH_RDY);
        add(0, LW,  0, 1, 4'd1,  O_DECODE);
        add(0, LW,  0, 1, 4'd2,  O_MEMADR);
        add(0, LW,  0, 1, 4'd3,  O_MEMRD);
        add(0, LW,  0, 1, 4'd4,  O_MEMWB);
        // beq taken then not taken
        add(0, BEQ, 1, 1, 4'd0,  O_FETCH_RDY);
        add(0, BEQ, 1, 1, 4'd1,  O_DECODE);
        add(0, BEQ, 1, 1, 4'd8,  O_BR_TAKEN);
        add(0, BEQ, 0, 1, 4'd0,  O_FETCH_RDY);
        add(0, BEQ, 0, 1, 4'd1,  O_DECODE);
        add(0, BEQ, 0, 1, 4'd8,  O_BR_NOT);
        // sw with a three-cycle stall in MEMWR
        add(0, SW,  0, 1, 4'd0,  O_FETCH_RDY);
        add(0, SW,  0, 1, 4'd1,  O_DECODE);
        add(0, SW,  0, 1, 4'd2,  O_MEMADR);
        add(0, SW,  0, 0, 4'd5,  O_MEMWR);
        add(0, SW,  0, 0, 4'd5,  O_MEMWR);
        add(0, SW,  0, 0, 4'd5,  O_MEMWR);
        add(0, SW,  0, 1, 4'd5,  O_MEMWR);
        // fetch stall, then jump
        add(0, JMP, 1, 0, 4'd0,  O_FETCH_STL);
        add(0, JMP, 1, 0, 4'd0,  O_FETCH_STL);
        add(0, JMP, 1, 1, 4'd0,  O_FETCH_RDY);
        add(0, JMP, 0, 1, 4'd1,  O_DECODE);
        add(0, JMP, 0, 1, 4'd9,  O_JUMP);
        // unknown opcode is a NOP
        add(0, BAD, 0, 1, 4'd0,  O_FETCH_RDY);
        add(0, BAD, 1, 1, 4'd1,  O_DECODE);
        // R-type aborted by reset in ALUWB
        add(0, RT,  0, 1, 4'd0,  O_FETCH_RDY);
        add(0, RT,  0, 1, 4'd1,  O_DECODE);
        add(0, RT,  0, 1, 4'd6,  O_EXEC);
        add(1, RT,  0, 1, 4'd7,  O_ALUWB);
        // addi after the aborted instruction
        add(0, ADDI, 0, 1, 4'd0,  O_FETCH_RDY);
        add(0, ADDI, 0, 1, 4'd1,  O_DECODE);
        add(0, ADDI, 0, 1, 4'd10, O_MEMADR);
        add(0, ADDI, 0, 1, 4'd11, O_ADDIWB);
        // lw stalled in MEMRD, reset mid-stall
        add(0, LW,  0, 1, 4'd0,  O_FETCH_RDY);
        add(0, LW,  0, 1, 4'd1,  O_DECODE);
        add(0, LW,  0, 1, 4'd2,  O_MEMADR);
        add(0, LW,  0, 0, 4'd3,  O_MEMRD);
        add(1, LW,  0, 0, 4'd3,  O_MEMRD);
        add(0, LW,  0, 0, 4'd0,  O_FETCH_STL);

        reset = 1'b1; Op = 6'd0; Zero = 1'b0; MemReady = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < vq.size(); i++) begin
            reset = vq[i].rst; Op = vq[i].op; Zero = vq[i].zero; MemReady = vq[i].mr;
            @(negedge clk);
            total++;
            if (State !== vq[i].st) begin
                bad++;
                $display("FAIL row%0d state: got %0d want %0d", i, State, vq[i].st);
            end
            total++;
            if (act !== vq[i].o) begin
                bad++;
                $display("FAIL row%0d outputs: got %h want %h", i, act, vq[i].o);
            end
            @(posedge clk);
            #1;
        end

        // Instruction latencies from FETCH back to FETCH with MemReady held high
        run_latency(LW,   5);
        run_latency(SW,   4);
        run_latency(RT,   4);
        run_latency(ADDI, 4);
        run_latency(BEQ,  3);
        run_latency(JMP,  3);
        run_latency(BAD,  2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 No parameters.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  one clock; reset is synchronous and active-high.
REQ-004 Op  input  6  opcode field of the instruction register.
REQ-005 Zero  input  1  ALU zero flag for the current cycle.
REQ-006 MemReady  input  1  memory handshake: access completes in the cycle this is 1.
REQ-007 PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  output  1 each  datapath strobes and mux selects.
REQ-008 PCEn  output  1  PC load enable = PCWrite | (PCWriteCond & Zero).
REQ-009 ALUOp  output  2  code to the ALU control decoder: 00 add, 01 subtract, 10 decode funct.
REQ-010 ALUSrcB, PCSource  output  2 each  mux selects.
REQ-011 State  output  4  current state encoding, for debug.

Function
REQ-012 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11; encodings 12-15 are illegal.
REQ-013 FETCH -> DECODE when MemReady=1; otherwise remain in FETCH.
REQ-014 DECODE dispatch on Op: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 000010 -> JUMP, 001000 -> ADDIEX, any other opcode -> FETCH (instruction treated as NOP).
REQ-015 MEMADR -> MEMRD if Op=100011, else -> MEMWR.
REQ-016 MEMRD -> MEMWB when MemReady=1, else hold; MEMWR -> FETCH when MemReady=1, else hold.
REQ-017 Unconditional transitions: MEMWB, ALUWB, BRANCH, JUMP and ADDIWB -> FETCH; EXEC -> ALUWB; ADDIEX -> ADDIWB.
REQ-018 An illegal state encoding SHALL go to FETCH on the next edge.
REQ-019 Outputs are 0 in every state unless listed below.
REQ-020 FETCH outputs: MemRead=1, ALUSrcB=01, ALUOp=00, PCSource=00; IRWrite=1 and PCWrite=1 only in the cycle MemReady=1.
REQ-021 DECODE outputs: ALUSrcB=11, ALUOp=00.
REQ-022 MEMADR and ADDIEX outputs: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
REQ-023 MEMRD outputs: MemRead=1, IorD=1.
REQ-024 MEMWR outputs: MemWrite=1, IorD=1 in every cycle of the state, including stall cycles.
REQ-025 MEMWB outputs: MemtoReg=1, RegWrite=1, RegDst=0.
REQ-026 EXEC outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
REQ-027 ALUWB outputs: RegDst=1, RegWrite=1.
REQ-028 BRANCH outputs: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
REQ-029 JUMP outputs: PCWrite=1, PCSource=10.
REQ-030 ADDIWB outputs: RegWrite=1, RegDst=0, MemtoReg=0.
REQ-031 Latency with MemReady held at 1: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles; unknown opcode 2 cycles.
REQ-032 Outputs other than IRWrite, PCWrite and PCEn depend only on State. IRWrite, PCWrite and PCEn also depend on MemReady or Zero in the same cycle; these three paths are combinational.

Reset
REQ-033 While reset=1 at a rising edge, State becomes FETCH; reset takes priority over every transition, including one in mid-instruction or mid-stall.
REQ-034 After reset the outputs SHALL equal the FETCH decode of REQ-020; RegWrite, MemWrite and PCWriteCond are 0.

Verification
REQ-035 Reset, then Op=100011 with MemReady=1 -> State sequence 0,1,2,3,4,0; RegWrite=1 only in state 4.
REQ-036 Op=000100: with Zero=1 in BRANCH -> PCEn=1 and PCSource=01; repeated with Zero=0 -> PCEn=0. Both cases return to state 0 after 3 cycles.
REQ-037 Op=101011 with MemReady=0 for 3 cycles in MEMWR -> State holds at 5 with MemWrite=1 for 4 cycles in total, then returns to 0.
REQ-038 FETCH with MemReady=0 for 2 cycles -> IRWrite=0 and PCWrite=0 during the stall; both are 1 in the cycle MemReady rises.
REQ-039 Op=111111 -> State sequence 0,1,0 with RegWrite, MemWrite and PCEn held at 0 after FETCH.
REQ-040 Assert reset during ALUWB (State=7) of an R-type instruction -> State=0 on the next edge with RegWrite=0.
